// File: rtl/q_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (q_div, q_mul).
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 256
`endif

package q_pkg;

  // Divider FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Saturation limits for the default Q-format word.
  localparam int unsigned Q_WIDTH = `FIXED_WIDTH;
  localparam logic [Q_WIDTH-1:0] Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

endpackage

// File: rtl/q_sat.sv
// Saturates an unsigned magnitude plus sign flag into a WIDTH-bit two's complement word.
module q_sat #(
  parameter int WIDTH = 16,
  parameter int MAG_W = 24
) (
  input  logic [MAG_W-1:0] mag,
  input  logic             neg,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(64'd1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamp to the representable range; negatives may reach one further than positives.
  always_comb begin
    ovf    = 1'b0;
    result = mag[WIDTH-1:0];
    if (neg) begin
      if (mag > NEG_LIM) begin
        ovf    = 1'b1;
        result = SAT_MIN;
      end else begin
        result = -mag[WIDTH-1:0];
      end
    end else if (mag > POS_LIM) begin
      ovf    = 1'b1;
      result = SAT_MAX;
    end
  end

endmodule

// File: rtl/q_div.sv
// Signed Q-format divider: restoring division, one quotient bit per cycle.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 256
`endif

module q_div
  import q_pkg::*;
#(
  parameter int WIDTH     = `FIXED_WIDTH,
  parameter int FRAC_BITS = $clog2(`SCALE_FACTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int QW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] ITERS = CW'(QW);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic             neg_q;      // quotient sign, or dividend sign on divide-by-zero
  logic             zero_q;     // divisor was zero
  logic [WIDTH-1:0] mag_b_q;
  logic [WIDTH-1:0] rem_q;
  logic [QW-1:0]    quo_q;      // dividend bits shift out the top, quotient bits in the bottom
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q, ovf_q, done_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             b_zero;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] sat_result;
  logic             sat_ovf;

  // Operand magnitudes; WIDTH-bit unsigned so the most negative value is exact.
  always_comb begin
    mag_a  = a[WIDTH-1] ? -a : a;
    mag_b  = b[WIDTH-1] ? -b : b;
    b_zero = (b == '0);
  end

  // One restoring step; the difference always fits WIDTH bits when ge holds.
  always_comb begin
    rem_sh = {rem_q, quo_q[QW-1]};
    ge     = (rem_sh >= {1'b0, mag_b_q});
    rem_nx = ge ? (rem_sh[WIDTH-1:0] - mag_b_q) : rem_sh[WIDTH-1:0];
  end

  q_sat #(
    .WIDTH (WIDTH),
    .MAG_W (QW)
  ) u_sat (
    .mag    (quo_q),
    .neg    (neg_q),
    .result (sat_result),
    .ovf    (sat_ovf)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = b_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CW'(1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      mag_b_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            zero_q  <= b_zero;
            neg_q   <= b_zero ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
            mag_b_q <= mag_b;
            rem_q   <= '0;
            quo_q   <= {mag_a, {FRAC_BITS{1'b0}}};
            cnt_q   <= ITERS;
          end
        end
        ST_CALC: begin
          rem_q <= rem_nx;
          quo_q <= {quo_q[QW-2:0], ge};
          cnt_q <= cnt_q - CW'(1);
        end
        ST_DONE: begin
          done_q <= 1'b1;
          dbz_q  <= zero_q;
          if (zero_q) begin
            result_q <= neg_q ? SAT_MIN : SAT_MAX;
            ovf_q    <= 1'b0;
          end else begin
            result_q <= sat_result;
            ovf_q    <= sat_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready       = (state_q == ST_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
